// File: rtl/spi_adc_pkg.sv
// Shared FSM state type, default frame geometry and counter-width helpers for the
// multi-lane serial ADC controller.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam int N_CH_DEF      = 2;
  localparam int DATA_W_DEF    = 12;
  localparam int LEAD_BITS_DEF = 2;
  localparam int CLK_DIV_DEF   = 2;
  localparam int CS_IDLE_DEF   = 4;

  // Standard ADS7883 frame length in SCLK cycles.
  localparam int FRAME = 16;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_len(input int lead, input int data, input int trail);
    return lead + data + trail;
  endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// One SDO lane: MSB-first shift register plus the output register that publishes
// the completed word when the frame ends.
module adc_shift_lane #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              capture,
  input  logic              sdo,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      data <= '0;
    end else begin
      if (shift_en) sr <= {sr[DATA_W-2:0], sdo};
      if (capture)  data <= sr;
    end
  end

endmodule

// File: rtl/spi_adc_multi_ctrl.sv
// Frame controller driving one shared SCLK/nCS to N_CH serial ADCs and capturing
// all SDO lanes in parallel; single-shot or continuous conversion.
module spi_adc_multi_ctrl
  import spi_adc_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEAD_BITS  = LEAD_BITS_DEF,
  parameter int TRAIL_BITS = FRAME - LEAD_BITS_DEF - DATA_W_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int CS_IDLE    = CS_IDLE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     start,
  input  logic [N_CH-1:0]          adc_sdo,
  output logic                     adc_sclk,
  output logic                     adc_ncs,
  output logic [N_CH*DATA_W-1:0]   adc_data,
  output logic                     valid,
  output logic                     busy
);

  localparam int FRAME_BITS = frame_len(LEAD_BITS, DATA_W, TRAIL_BITS);
  localparam int HW = cnt_w(CLK_DIV);
  localparam int EW = cnt_w(2 * FRAME_BITS);
  localparam int QW = cnt_w(CS_IDLE);

  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_PRE  = HW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [EW-1:0] E_LAST = EW'(2 * FRAME_BITS - 1);
  localparam logic [EW-1:0] E_PRE  = EW'(2 * FRAME_BITS - 2);
  localparam logic [QW-1:0] Q_LAST = QW'(CS_IDLE - 1);

  state_t        state;
  logic [HW-1:0] hcnt;   // clk cycles within the current half-period
  logic [EW-1:0] ecnt;   // SCLK half-period index; even = low, odd = high
  logic [QW-1:0] qcnt;

  logic half_done, fall_now, shift_en, capture, ncs_rise;
  int   fall_idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    half_done = (hcnt == H_LAST);
    fall_now  = 1'b0;
    fall_idx  = 0;
    if (state == SETUP && half_done) begin
      fall_now = 1'b1;
      fall_idx = 1;
    end else if (state == SHIFT && half_done && adc_sclk && ecnt != E_LAST) begin
      fall_now = 1'b1;
      fall_idx = int'(ecnt >> 1) + 2;
    end
    shift_en = fall_now && fall_idx > LEAD_BITS && fall_idx <= LEAD_BITS + DATA_W;
    capture  = (state == SHIFT) && half_done && (ecnt == E_LAST);
    // nCS is released one cycle before SHIFT ends.
    ncs_rise = (state == SHIFT) &&
               ((CLK_DIV == 1) ? (ecnt == E_PRE) : (ecnt == E_LAST && hcnt == H_PRE));
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      ecnt     <= '0;
      qcnt     <= '0;
      adc_sclk <= 1'b1;
      adc_ncs  <= 1'b1;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && (mode || start)) begin
            state   <= SETUP;
            hcnt    <= '0;
            adc_ncs <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          if (half_done) begin
            state    <= SHIFT;
            hcnt     <= '0;
            ecnt     <= '0;
            adc_sclk <= 1'b0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (ncs_rise) adc_ncs <= 1'b1;
          if (!half_done) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (ecnt == E_LAST) begin
              state <= QUIET;
              qcnt  <= '0;
              valid <= 1'b1;
            end else begin
              ecnt     <= ecnt + 1'b1;
              adc_sclk <= ~adc_sclk;
            end
          end
        end
        QUIET: begin
          if (qcnt == Q_LAST) begin
            if (en && mode) begin
              state   <= SETUP;
              hcnt    <= '0;
              adc_ncs <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            qcnt <= qcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    adc_shift_lane #(.DATA_W(DATA_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .capture  (capture),
      .sdo      (adc_sdo[k]),
      .data     (adc_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_spi_adc_multi_ctrl.sv
// Scoreboard bench: behavioural ADS7883-style SDO models feed a default build and a
// fast 4-lane build; a monitor pops expected samples on every valid pulse.
module tb_spi_adc_multi_ctrl;
  localparam int LEAD = 2, TRAIL = 2, CSI = 4;
  localparam int N0 = 2, W0 = 12, D0 = 2, F0 = LEAD + W0 + TRAIL;
  localparam int N1 = 4, W1 = 16, D1 = 1, F1 = LEAD + W1 + TRAIL;
  localparam int LAT0 = 67, PER0 = 70, LAT1 = 42, PER1 = 45;

  logic clk = 1'b0, rst = 1'b1;
  logic en0 = 1'b0, mode0 = 1'b0, start0 = 1'b0;
  logic en1 = 1'b0, mode1 = 1'b0, start1 = 1'b0;
  logic [N0-1:0] sdo0;
  logic [N1-1:0] sdo1;
  logic sclk0, ncs0, valid0, busy0, sclk1, ncs1, valid1, busy1;
  logic [N0*W0-1:0] data0;
  logic [N1*W1-1:0] data1;

  int tests = 0, fails = 0, cyc = 0;

  spi_adc_multi_ctrl #(.N_CH(N0), .DATA_W(W0), .LEAD_BITS(LEAD), .TRAIL_BITS(TRAIL),
                       .CLK_DIV(D0), .CS_IDLE(CSI)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .mode(mode0), .start(start0), .adc_sdo(sdo0),
    .adc_sclk(sclk0), .adc_ncs(ncs0), .adc_data(data0), .valid(valid0), .busy(busy0));

  spi_adc_multi_ctrl #(.N_CH(N1), .DATA_W(W1), .LEAD_BITS(LEAD), .TRAIL_BITS(TRAIL),
                       .CLK_DIV(D1), .CS_IDLE(CSI)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .start(start1), .adc_sdo(sdo1),
    .adc_sclk(sclk1), .adc_ncs(ncs1), .adc_data(data1), .valid(valid1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit p (1-based) of a frame: leading/trailing slots read 1, data goes MSB first.
  function automatic logic frame_bit(input logic [63:0] w, input int dw, input int p);
    if (p <= LEAD || p > LEAD + dw) return 1'b1;
    return w[dw - 1 - (p - LEAD - 1)];
  endfunction

  // ADC models: new word on nCS fall, next bit presented after every SCLK fall.
  logic [W0-1:0] word0 [N0];
  logic [W1-1:0] word1 [N1];
  int pos0 = 0, pos1 = 0, falls0 = 0, falls1 = 0, hi0 = 0, hi1 = 0;
  logic [W0-1:0] force0 [$];
  logic [W1-1:0] force1 [$];
  logic [N0*W0-1:0] exp0 [$];
  logic [N1*W1-1:0] exp1 [$];
  int vt0 [$], vt1 [$];

  always_comb for (int k = 0; k < N0; k++) sdo0[k] = frame_bit(64'(word0[k]), W0, pos0);
  always_comb for (int k = 0; k < N1; k++) sdo1[k] = frame_bit(64'(word1[k]), W1, pos1);

  always @(negedge ncs0) begin : launch0
    logic [N0*W0-1:0] e;
    for (int k = 0; k < N0; k++) begin
      word0[k] = (force0.size() > 0) ? force0.pop_front() : W0'($urandom);
      e[k*W0 +: W0] = word0[k];
    end
    exp0.push_back(e);
    pos0 = 1;
    falls0 = 0;
  end

  always @(negedge ncs1) begin : launch1
    logic [N1*W1-1:0] e;
    for (int k = 0; k < N1; k++) begin
      word1[k] = (force1.size() > 0) ? force1.pop_front() : W1'($urandom);
      e[k*W1 +: W1] = word1[k];
    end
    exp1.push_back(e);
    pos1 = 1;
    falls1 = 0;
  end

  always @(negedge sclk0) if (ncs0 === 1'b0) begin pos0++; falls0++; end
  always @(negedge sclk1) if (ncs1 === 1'b0) begin pos1++; falls1++; end
  always @(posedge ncs0) if (rst === 1'b0) check("d0 sclk falls per frame", falls0, F0);
  always @(posedge ncs1) if (rst === 1'b0) check("d1 sclk falls per frame", falls1, F1);

  // Monitor: scoreboard pop on valid, nCS gap between frames.
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      vt0.push_back(cyc);
      check("d0 frame pending at valid", exp0.size() > 0, 1);
      if (exp0.size() > 0) check("d0 data", data0, exp0.pop_front());
      check("d0 ncs/busy at valid", {ncs0, busy0}, 2'b11);
    end
    if (valid1 === 1'b1) begin
      vt1.push_back(cyc);
      check("d1 frame pending at valid", exp1.size() > 0, 1);
      if (exp1.size() > 0) check("d1 data", data1, exp1.pop_front());
      check("d1 ncs/busy at valid", {ncs1, busy1}, 2'b11);
    end
    if (ncs0 === 1'b0 && hi0 > 0) check("d0 ncs high gap", hi0 >= CSI, 1);
    if (ncs1 === 1'b0 && hi1 > 0) check("d1 ncs high gap", hi1 >= CSI, 1);
    hi0 = (ncs0 === 1'b1) ? hi0 + 1 : 0;
    hi1 = (ncs1 === 1'b1) ? hi1 + 1 : 0;
  end

  task automatic pulse_start(input int u, output int t0);
    @(negedge clk);
    t0 = cyc;
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_valid(input int u, input int target, input int budget);
    int n = 0;
    while (((u == 0) ? vt0.size() : vt1.size()) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget)
      check((u == 0) ? "d0 valid timeout" : "d1 valid timeout",
            (u == 0) ? vt0.size() : vt1.size(), target);
  endtask

  task automatic wait_idle(input int u, input int budget);
    int n = 0;
    while (((u == 0) ? busy0 : busy1) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((u == 0) ? "d0 returns idle" : "d1 returns idle", (u == 0) ? busy0 : busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, nv, n;
    repeat (3) @(negedge clk);
    check("d0 reset outputs", {sclk0, ncs0, valid0, busy0, data0}, {4'b1100, 24'h0});
    check("d1 reset ctrl", {sclk1, ncs1, valid1, busy1}, 4'b1100);
    check("d1 reset data", data1, 64'h0);
    rst = 1'b0;

    // Single-shot with known words; a start during busy must not queue a frame.
    en0 = 1'b1; mode0 = 1'b0;
    force0.push_back(12'hA5C); force0.push_back(12'h3F1);
    pulse_start(0, t0);
    repeat (30) @(negedge clk);
    check("d0 busy mid-frame", busy0, 1);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    wait_valid(0, 1, 200);
    if (vt0.size() > 0) check("d0 single-shot latency", vt0[0] - t0, LAT0);
    check("d0 single-shot data", data0, 24'h3F1A5C);
    repeat (150) @(negedge clk);
    check("d0 no extra frame", vt0.size(), 1);
    check("d0 idle after single-shot", {ncs0, busy0}, 2'b10);

    // start with en low is ignored.
    en0 = 1'b0;
    pulse_start(0, t0);
    repeat (20) @(negedge clk);
    check("d0 start ignored when disabled", {ncs0, busy0}, 2'b10);

    // Continuous: five random frames at a fixed period.
    nv = vt0.size();
    en0 = 1'b1; mode0 = 1'b1;
    wait_valid(0, nv + 5, 6 * PER0);
    en0 = 1'b0;
    wait_idle(0, 200);
    check("d0 continuous frame count", vt0.size(), nv + 5);
    for (int i = nv + 1; i < nv + 5 && i < vt0.size(); i++)
      check("d0 continuous period", vt0[i] - vt0[i-1], PER0);

    // Boundary words: all ones then all zeros.
    nv = vt0.size();
    force0.push_back(12'hFFF); force0.push_back(12'hFFF);
    force0.push_back(12'h000); force0.push_back(12'h000);
    en0 = 1'b1;
    wait_valid(0, nv + 1, 200);
    check("d0 all-ones capture", data0, 24'hFFFFFF);
    wait_valid(0, nv + 2, 200);
    en0 = 1'b0;
    wait_idle(0, 200);
    check("d0 all-zeros capture", data0, 24'h000000);
    check("d0 boundary frame count", vt0.size(), nv + 2);

    // en dropped 20 cycles into SHIFT: frame still delivered, then IDLE.
    nv = vt0.size();
    en0 = 1'b1;
    n = 0;
    while (ncs0 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("d0 frame launched", ncs0, 0);
    repeat (D0 + 20) @(negedge clk);
    en0 = 1'b0;
    wait_valid(0, nv + 1, 200);
    wait_idle(0, 50);
    check("d0 idle after en drop", {ncs0, busy0}, 2'b10);
    repeat (150) @(negedge clk);
    check("d0 en-drop frame count", vt0.size(), nv + 1);

    // Fast 4-lane build: single-shot latency, ignored start, continuous period.
    en1 = 1'b1; mode1 = 1'b0;
    pulse_start(1, t0);
    repeat (15) @(negedge clk);
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    wait_valid(1, 1, 200);
    if (vt1.size() > 0) check("d1 single-shot latency", vt1[0] - t0, LAT1);
    repeat (100) @(negedge clk);
    check("d1 no extra frame", vt1.size(), 1);
    nv = vt1.size();
    force1.push_back(16'hFFFF); force1.push_back(16'h0000);
    force1.push_back(16'h8001); force1.push_back(16'h7FFE);
    mode1 = 1'b1;
    wait_valid(1, nv + 3, 4 * PER1);
    en1 = 1'b0;
    wait_idle(1, 200);
    check("d1 continuous frame count", vt1.size(), nv + 3);
    for (int i = nv + 1; i < nv + 3 && i < vt1.size(); i++)
      check("d1 continuous period", vt1[i] - vt1[i-1], PER1);

    // Reset in the middle of SHIFT discards the partial frame.
    nv = vt0.size();
    en0 = 1'b1; mode0 = 1'b0;
    pulse_start(0, t0);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("d0 mid-frame reset outputs", {sclk0, ncs0, valid0, busy0, data0}, {4'b1100, 24'h0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp0.delete();
    repeat (150) @(negedge clk);
    check("d0 no valid after reset", vt0.size(), nv);
    check("d0 idle after reset", {sclk0, ncs0, busy0}, 3'b110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
